// File: rtl/mem_arbiter_if.sv
// Memory-port types and the requester/memory bus bundle shared by mem_arbiter and its users.
package mem_arbiter_pkg;
    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        write_byte = 2'd0,
        write_half = 2'd1,
        write_word = 2'd2
    } mem_width_t;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic            wenable;
        logic [XLEN-1:0] wdata;
        mem_width_t      wwidth;
    } mem_control_t;
endpackage

interface mem_arbiter_if #(
    parameter int NUM_REQ = 2
);
    import mem_arbiter_pkg::*;

    logic [NUM_REQ-1:0] req;
    mem_control_t       req_ctrl [NUM_REQ];
    logic [NUM_REQ-1:0] lock;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] rvalid;
    logic [XLEN-1:0]    rdata;
    mem_control_t       mem_ctrl;
    logic [XLEN-1:0]    mem_rdata;

    // Arbiter side: sees requests and read data, drives grants and the memory port.
    modport slave (
        input  req, req_ctrl, lock, mem_rdata,
        output gnt, rvalid, rdata, mem_ctrl
    );

    // Requester/memory side: the mirror image of the arbiter.
    modport master (
        output req, req_ctrl, lock, mem_rdata,
        input  gnt, rvalid, rdata, mem_ctrl
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter with bounded locking that shares one synchronous memory port
// between NUM_REQ requesters and steers read data back to the requester that issued it.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int MAX_LOCK = 4
) (
    input  logic         clock,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    typedef logic [IDX_W-1:0] idx_t;

    // Registered arbitration state.
    idx_t       rr_ptr;
    idx_t       owner;
    logic       owner_valid;
    logic [3:0] lock_cnt;
    logic       rd_pending;
    idx_t       rd_owner;

    // Combinational decision for the current cycle.
    logic               lock_hold;
    logic               grant_any;
    logic               grant;
    idx_t               winner;
    idx_t               cand;
    idx_t               next_ptr;
    logic [NUM_REQ-1:0] search_req;

    // Pick this cycle's winner: locked owner first, otherwise round-robin from rr_ptr.
    always_comb begin
        // NOTE: every variable gets a value before any condition so no path can infer a latch.
        lock_hold  = 1'b0;
        grant_any  = 1'b0;
        winner     = rr_ptr;
        cand       = '0;
        search_req = bus.req;

        lock_hold = owner_valid && bus.lock[owner] && bus.req[owner]
                    && (lock_cnt < 4'(MAX_LOCK));

        // An owner that used up its lock sits out one search, unless nobody else wants the port.
        if (owner_valid && (lock_cnt == 4'(MAX_LOCK))
            && ((bus.req & ~(NUM_REQ'(1) << owner)) != '0)) begin
            search_req[owner] = 1'b0;
        end

        if (lock_hold) begin
            grant_any = 1'b1;
            winner    = owner;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = idx_t'((int'(rr_ptr) + k) % NUM_REQ);
                if (!grant_any && search_req[cand]) begin
                    grant_any = 1'b1;
                    winner    = cand;
                end
            end
        end

        next_ptr = (winner == idx_t'(NUM_REQ - 1)) ? '0 : winner + idx_t'(1);
    end

    // Drive grants, the memory port and the read-return strobe; reset blocks all of them.
    always_comb begin
        grant        = grant_any && !reset;
        bus.gnt      = '0;
        if (grant) begin
            bus.gnt[winner] = 1'b1;
        end

        bus.mem_ctrl         = bus.req_ctrl[winner];
        bus.mem_ctrl.wenable = grant && bus.req_ctrl[winner].wenable;

        bus.rvalid = '0;
        if (rd_pending) begin
            bus.rvalid[rd_owner] = 1'b1;
        end

        bus.rdata = bus.mem_rdata;
    end

    // Record the grant: owner, next priority, lock run length and any read awaiting data.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            rr_ptr      <= '0;
            owner       <= '0;
            owner_valid <= 1'b0;
            lock_cnt    <= '0;
            rd_pending  <= 1'b0;
            rd_owner    <= '0;
        end else if (grant_any) begin
            owner       <= winner;
            owner_valid <= 1'b1;
            rr_ptr      <= next_ptr;
            if (lock_hold) begin
                lock_cnt <= lock_cnt + 4'd1;
            end else if (bus.lock[winner]) begin
                lock_cnt <= 4'd1;
            end else begin
                lock_cnt <= '0;
            end
            rd_pending <= !bus.req_ctrl[winner].wenable;
            rd_owner   <= winner;
        end else begin
            owner_valid <= 1'b0;
            lock_cnt    <= '0;
            rd_pending  <= 1'b0;
        end
    end
endmodule
